// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline register stage with stall, flush and bubble handling.
// Optional build macro PIPE_STAGE_STATS_EN adds saturating 16-bit event counters.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   in_valid/in_ctrl/in_data/in_aux/in_rd   upstream stage contents
//   stall, flush       hold the contents / replace them with a bubble (flush wins)
//   out_valid/out_ctrl/out_data/out_aux/out_rd   registered stage contents
//   cnt_load/cnt_bubble/cnt_stall/cnt_flush   event counters (PIPE_STAGE_STATS_EN only)
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AUX_W  = 32,
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned RW_BIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AUX_W-1:0]  in_aux,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [AUX_W-1:0]  out_aux,
  output logic [RD_W-1:0]   out_rd
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [15:0]       cnt_load,
  output logic [15:0]       cnt_bubble,
  output logic [15:0]       cnt_stall,
  output logic [15:0]       cnt_flush
`endif
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [AUX_W-1:0]  aux_q,   aux_d;
  logic [RD_W-1:0]   rd_q,    rd_d;

  // Action decode: flush beats stall, load only when neither is asserted
  logic do_flush, do_stall, do_load;
  assign do_flush = flush;
  assign do_stall = ~flush & stall;
  assign do_load  = ~flush & ~stall;

  // A register write to index 0 is architecturally a no-op, so drop the write flag
  logic [CTRL_W-1:0] ctrl_load;
  always_comb begin
    ctrl_load         = in_ctrl;
    ctrl_load[RW_BIT] = in_ctrl[RW_BIT] & (in_rd != '0);
  end

  // Next-state selection for the stage contents
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    aux_d   = aux_q;
    rd_d    = rd_q;
    if (do_flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (do_load) begin
      valid_d = in_valid;
      ctrl_d  = in_valid ? ctrl_load : '0;
      data_d  = in_data;
      aux_d   = in_aux;
      rd_d    = in_rd;
    end
  end

  // Stage register
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
      aux_q   <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      aux_q   <= aux_d;
      rd_q    <= rd_d;
    end
  end

  assign out_valid = valid_q;
  assign out_ctrl  = ctrl_q;
  assign out_data  = data_q;
  assign out_aux   = aux_q;
  assign out_rd    = rd_q;

`ifdef PIPE_STAGE_STATS_EN
  localparam int unsigned CNT_W = 16;

  logic [CNT_W-1:0] load_q, bubble_q, stall_q, flush_q;
  logic [CNT_W-1:0] load_d, bubble_d, stall_d, flush_d;

  // Exactly one counter advances per non-reset edge; each sticks at all-ones
  always_comb begin
    load_d   = load_q;
    bubble_d = bubble_q;
    stall_d  = stall_q;
    flush_d  = flush_q;
    if (do_flush) begin
      if (flush_q != '1) flush_d = flush_q + CNT_W'(1);
    end else if (do_stall) begin
      if (stall_q != '1) stall_d = stall_q + CNT_W'(1);
    end else if (in_valid) begin
      if (load_q != '1) load_d = load_q + CNT_W'(1);
    end else begin
      if (bubble_q != '1) bubble_d = bubble_q + CNT_W'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      load_q   <= '0;
      bubble_q <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      load_q   <= load_d;
      bubble_q <= bubble_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
    end
  end

  assign cnt_load   = load_q;
  assign cnt_bubble = bubble_q;
  assign cnt_stall  = stall_q;
  assign cnt_flush  = flush_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and randomized checks of pipe_stage_reg against a
// behavioural model of the stage contents and (when PIPE_STAGE_STATS_EN) counters.
module tb_pipe_stage_reg;

  localparam int unsigned RW = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_ctrl = '0;
  logic [31:0] in_data = '0;
  logic [31:0] in_aux = '0;
  logic [4:0]  in_rd = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [3:0]  out_ctrl;
  logic [31:0] out_data;
  logic [31:0] out_aux;
  logic [4:0]  out_rd;
`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] cnt_load, cnt_bubble, cnt_stall, cnt_flush;
`endif

  pipe_stage_reg dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .in_aux    (in_aux),
    .in_rd     (in_rd),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .out_aux   (out_aux),
    .out_rd    (out_rd)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .cnt_load   (cnt_load),
    .cnt_bubble (cnt_bubble),
    .cnt_stall  (cnt_stall),
    .cnt_flush  (cnt_flush)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model of the architectural stage contents
  bit          m_valid = 0;
  logic [3:0]  m_ctrl = '0;
  logic [31:0] m_data = '0;
  logic [31:0] m_aux = '0;
  logic [4:0]  m_rd = '0;
  int          m_load = 0, m_bubble = 0, m_stall = 0, m_flush = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int x);
    return (x >= 65535) ? 65535 : x + 1;
  endfunction

  task automatic check_model();
    check("valid", 64'(out_valid), 64'(m_valid));
    check("ctrl",  64'(out_ctrl),  64'(m_ctrl));
    check("data",  64'(out_data),  64'(m_data));
    check("aux",   64'(out_aux),   64'(m_aux));
    check("rd",    64'(out_rd),    64'(m_rd));
    check("ctrl_zero_when_invalid", 64'(!out_valid && out_ctrl != 0), 64'(0));
`ifdef PIPE_STAGE_STATS_EN
    check("cnt_load",   64'(cnt_load),   64'(m_load));
    check("cnt_bubble", 64'(cnt_bubble), 64'(m_bubble));
    check("cnt_stall",  64'(cnt_stall),  64'(m_stall));
    check("cnt_flush",  64'(cnt_flush),  64'(m_flush));
`endif
  endtask

  // Apply one cycle of inputs, advance the model, clock, and optionally compare
  task automatic step(input bit r, input bit v, input logic [3:0] c, input logic [31:0] d,
                      input logic [31:0] a, input logic [4:0] rd, input bit s, input bit f,
                      input bit chk);
    rst = r; in_valid = v; in_ctrl = c; in_data = d; in_aux = a; in_rd = rd;
    stall = s; flush = f;
    if (r) begin
      m_valid = 0; m_ctrl = '0; m_data = '0; m_aux = '0; m_rd = '0;
      m_load = 0; m_bubble = 0; m_stall = 0; m_flush = 0;
    end else if (f) begin
      m_valid = 0; m_ctrl = '0;
      m_flush = sat_inc(m_flush);
    end else if (s) begin
      m_stall = sat_inc(m_stall);
    end else begin
      m_data = d; m_aux = a; m_rd = rd;
      if (v) begin
        m_valid = 1;
        m_ctrl = c;
        if (rd == 0) m_ctrl[RW] = 1'b0;
        m_load = sat_inc(m_load);
      end else begin
        m_valid = 0;
        m_ctrl = '0;
        m_bubble = sat_inc(m_bubble);
      end
    end
    @(posedge clk);
    #1;
    if (chk) check_model();
  endtask

  initial begin
    // Reset then load
    step(1, 0, 4'h0, 32'h0, 32'h0, 5'd0, 0, 0, 1);
    step(1, 0, 4'h0, 32'h0, 32'h0, 5'd0, 1, 1, 1);
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_data",  64'(out_data),  64'(0));
    step(0, 1, 4'b1011, 32'hDEADBEEF, 32'h12345678, 5'd7, 0, 0, 1);
    check("load_valid", 64'(out_valid), 64'(1));
    check("load_ctrl",  64'(out_ctrl),  64'(4'b1011));
    check("load_data",  64'(out_data),  64'(32'hDEADBEEF));
    check("load_aux",   64'(out_aux),   64'(32'h12345678));
    check("load_rd",    64'(out_rd),    64'(7));

    // Stall holds while inputs change, then flush beats stall
    for (int i = 0; i < 3; i++) begin
      step(0, i[0], 4'(i + 2), 32'(i * 99), 32'(i + 5), 5'(i + 9), 1, 0, 1);
      check("stall_data", 64'(out_data), 64'(32'hDEADBEEF));
      check("stall_ctrl", 64'(out_ctrl), 64'(4'b1011));
    end
    step(0, 1, 4'hF, 32'h1, 32'h2, 5'd3, 1, 1, 1);
    check("flush_valid", 64'(out_valid), 64'(0));
    check("flush_ctrl",  64'(out_ctrl),  64'(0));
    check("flush_data",  64'(out_data),  64'(32'hDEADBEEF));

    // Stall while bubble holds the bubble
    step(0, 1, 4'hF, 32'h5, 32'h6, 5'd8, 1, 0, 1);
    check("stall_bubble_valid", 64'(out_valid), 64'(0));

    // Write suppression for destination index 0
    step(0, 1, 4'b0001, 32'hA, 32'hB, 5'd0, 0, 0, 1);
    check("r0_valid", 64'(out_valid), 64'(1));
    check("r0_ctrl",  64'(out_ctrl),  64'(4'b0000));
    step(0, 1, 4'b0001, 32'hA, 32'hB, 5'd3, 0, 0, 1);
    check("r3_ctrl",  64'(out_ctrl),  64'(4'b0001));

    // Bubble load, then reset in the middle of a stall
    step(0, 0, 4'b1111, 32'hC0FFEE, 32'h77, 5'd12, 0, 0, 1);
    check("bubble_valid", 64'(out_valid), 64'(0));
    check("bubble_ctrl",  64'(out_ctrl),  64'(0));
    check("bubble_data",  64'(out_data),  64'(32'hC0FFEE));
    step(0, 1, 4'b1010, 32'h11112222, 32'h33334444, 5'd21, 0, 0, 1);
    step(0, 1, 4'b0110, 32'h5, 32'h6, 5'd1, 1, 0, 1);
    step(1, 1, 4'b0110, 32'h5, 32'h6, 5'd1, 1, 0, 1);
    check("midstall_rst", 64'({out_valid, out_ctrl, out_data, out_aux, out_rd}), 64'(0));
    step(0, 1, 4'b0100, 32'h99, 32'h98, 5'd2, 0, 0, 1);

`ifdef PIPE_STAGE_STATS_EN
    // Counter tally: 5 loads, 2 bubbles, 3 stalls, 1 flush
    step(1, 0, 4'h0, 32'h0, 32'h0, 5'd0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 4'h2, 32'(i), 32'(i), 5'(i + 1), 0, 0, 1);
    for (int i = 0; i < 2; i++) step(0, 0, 4'h2, 32'(i), 32'(i), 5'(i + 1), 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 4'h2, 32'(i), 32'(i), 5'(i + 1), 1, 0, 1);
    step(0, 1, 4'h2, 32'h0, 32'h0, 5'd1, 0, 1, 1);
    check("tally_load",   64'(cnt_load),   64'(5));
    check("tally_bubble", 64'(cnt_bubble), 64'(2));
    check("tally_stall",  64'(cnt_stall),  64'(3));
    check("tally_flush",  64'(cnt_flush),  64'(1));

    // Drive the stall counter to saturation, then push past it
    step(1, 0, 4'h0, 32'h0, 32'h0, 5'd0, 0, 0, 1);
    for (int i = 0; i < 65535; i++) step(0, 1, 4'h1, 32'h0, 32'h0, 5'd1, 1, 0, 0);
    check("sat_reach", 64'(cnt_stall), 64'(16'hFFFF));
    step(0, 1, 4'h1, 32'h0, 32'h0, 5'd1, 1, 0, 1);
    step(0, 1, 4'h1, 32'h0, 32'h0, 5'd1, 1, 0, 1);
    check("sat_hold", 64'(cnt_stall), 64'(16'hFFFF));
    step(1, 0, 4'h0, 32'h0, 32'h0, 5'd0, 0, 0, 1);
    check("sat_clear", 64'(cnt_stall), 64'(0));
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit r, v, s, f;
      logic [4:0] rd;
      r  = ($urandom_range(0, 99) < 3);
      f  = ($urandom_range(0, 99) < 12);
      s  = ($urandom_range(0, 99) < 25);
      v  = ($urandom_range(0, 99) < 70);
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      step(r, v, 4'($urandom), $urandom, $urandom, rd, s, f, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of primary datapath word (ALU result).
REQ-002 Parameter AUX_W, default 32, width of secondary word (store data).
REQ-003 Parameter CTRL_W, default 4, width of control-flag bundle.
REQ-004 Parameter RD_W, default 5, width of destination-register index.
REQ-005 Parameter RW_BIT, default 0, index of the register-write flag within the control bundle.
REQ-006 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 Port rst  input  1  synchronous, active-high reset; sampled only on clk rising edge.
REQ-008 Port in_valid  input  1  upstream stage holds a real instruction.
REQ-009 Port in_ctrl  input  CTRL_W  upstream control flags.
REQ-010 Port in_data  input  DATA_W  upstream primary word.
REQ-011 Port in_aux  input  AUX_W  upstream secondary word.
REQ-012 Port in_rd  input  RD_W  upstream destination index.
REQ-013 Port stall  input  1  hold the current contents.
REQ-014 Port flush  input  1  replace the contents with a bubble.
REQ-015 Ports out_valid (1), out_ctrl (CTRL_W), out_data (DATA_W), out_aux (AUX_W), out_rd (RD_W)  output  registered stage contents.

Function
REQ-016 Each edge SHALL apply exactly one action, in priority order: rst, then flush, then stall (hold), then load.
REQ-017 Load SHALL capture all in_* fields; visible on outputs one cycle after the edge (latency 1).
REQ-018 On load with in_valid=0, out_valid and out_ctrl SHALL become 0; out_data/out_aux/out_rd SHALL still capture inputs.
REQ-019 On load with in_valid=1, in_ctrl[RW_BIT]=1 and in_rd=0, the captured out_ctrl[RW_BIT] SHALL be 0; all other fields are captured unchanged.
REQ-020 Flush SHALL set out_valid=0 and out_ctrl=0; it SHALL leave out_data, out_aux and out_rd unchanged.
REQ-021 Stall SHALL hold every output bit unchanged, including while out_valid=0.
REQ-022 When flush and stall are both high, flush SHALL win.
REQ-023 Outputs SHALL be driven directly by flops, with no combinational path from any input to any output.
REQ-024 When out_valid=0, out_ctrl SHALL always be 0.

Reset
REQ-025 rst high at an edge SHALL drive every output to 0 on the following cycle, regardless of stall or flush.
REQ-026 Reset asserted while the stage is stalled or holds a valid instruction SHALL discard the held contents.
REQ-027 After rst deasserts, the first edge SHALL perform a normal flush, stall or load.

Configuration
REQ-028 Macro PIPE_STAGE_STATS_EN, when defined, SHALL add four 16-bit outputs: cnt_load, cnt_bubble, cnt_stall and cnt_flush.
REQ-029 With PIPE_STAGE_STATS_EN defined, exactly one counter SHALL increment per non-reset edge:
- cnt_load: load with in_valid=1.
- cnt_bubble: load with in_valid=0.
- cnt_stall: stall action.
- cnt_flush: flush action.
REQ-030 Counters SHALL saturate at 0xFFFF and SHALL clear to 0 on rst.
REQ-031 Without PIPE_STAGE_STATS_EN, the counter ports and logic SHALL be absent, and behaviour SHALL be otherwise identical.

Verification
REQ-032 Reset then load: rst for 2 cycles, then in_valid=1, in_ctrl=4'b1011, in_data=32'hDEADBEEF, in_aux=32'h12345678, in_rd=5'd7 -> next cycle out_valid=1, out_ctrl=4'b1011, out_data=32'hDEADBEEF, out_aux=32'h12345678, out_rd=7.
REQ-033 Hold, then flush priority:
- Load as in REQ-032, then stall=1 for 3 cycles while inputs change -> outputs hold 32'hDEADBEEF and ctrl 4'b1011 throughout.
- Then stall=1 and flush=1 together -> out_valid=0, out_ctrl=0, out_data still 32'hDEADBEEF.
REQ-034 r0 write suppression: in_valid=1, in_ctrl=4'b0001 (RW_BIT=0), in_rd=0 -> out_valid=1, out_ctrl=4'b0000; same with in_rd=3 -> out_ctrl=4'b0001.
REQ-035 Bubble and mid-stall reset:
- in_valid=0, in_ctrl=4'b1111 -> out_valid=0, out_ctrl=0.
- Then load a valid instruction, stall, and assert rst during the stall -> all outputs 0 on the next cycle.
REQ-036 Stats (PIPE_STAGE_STATS_EN defined):
- 5 valid loads, 2 bubbles, 3 stalls, 1 flush -> counters read 5/2/3/1.
- Hold cnt_stall at 0xFFFF, then 2 more stalls -> cnt_stall stays 0xFFFF.
